ins_cache_ctrl: RTL
===================

// Module: ins_cache_ctrl
// PURPOSE
//  Direct-mapped instruction cache; the requesting side of the 128-bit block instruction-memory read interface.
//  Serves 32-bit instruction fetches from the IF stage and stalls the pipeline via cpu_busywait while a block is fetched.
//  Miss handling: issues a block read (mem_read / mem_address), waits on mem_busywait, then installs mem_readdata.
// PARAMETERS
//  INDEX_W   3   index bits; NUM_BLOCKS = 2**INDEX_W = 8 lines of 16 bytes
//  TAG_W     25  tag bits = 28 - INDEX_W (block address is cpu_address[31:4])
// PORTS
//  clock          in   1    system clock; all state updates on posedge
//  reset          in   1    synchronous, active-high
//  cpu_read       in   1    fetch request; cpu_address held stable while cpu_busywait=1
//  cpu_address    in   32   byte address; [1:0] ignored, [3:2] word select, [3+INDEX_W:4] index, [31:4+INDEX_W] tag
//  cpu_instr      out  32   fetched instruction word
//  cpu_busywait   out  1    stall to pipeline
//  mem_read       out  1    block read request to instruction memory
//  mem_address    out  28   block address (byte address >> 4)
//  mem_readdata   in   128  block; byte k of block at bits [8k+7:8k], word w at [32w+31:32w]
//  mem_busywait   in   1    memory busy; low while mem_read=1 after >=1 cycle = readdata valid
//  hit_count      out  32   hits counter (ICACHE_STATS_EN only, else 0)
//  miss_count     out  32   misses counter (ICACHE_STATS_EN only, else 0)
// BEHAVIOUR
//  Storage: data[NUM_BLOCKS] x128, tag[NUM_BLOCKS] xTAG_W, valid[NUM_BLOCKS] x1.
//  hit = cpu_read & valid[idx] & (tag[idx]==addr_tag); combinational.
//  States: IDLE, MEM_READ, UPDATE. Reset: state=IDLE, all valid=0, mem_read=0, mem_address=0, cpu_instr=0, cpu_busywait=0.
//  IDLE: hit -> cpu_instr = data[idx] word [3:2], cpu_busywait=0 same cycle (zero-wait hit).
//        cpu_read & !hit -> cpu_busywait=1 combinationally; latch miss block addr; go MEM_READ
//        only if mem_busywait=0 (stale responder activity after reset drains first; stay IDLE, stall).
//        cpu_read=0 -> cpu_busywait=0, no memory traffic, cpu_instr holds last value.
//  MEM_READ: mem_read=1, mem_address=latched cpu_address[31:4], cpu_busywait=1.
//        Exit to UPDATE on posedge where mem_busywait=0 and state has been MEM_READ >=1 full cycle.
//  UPDATE: on entry posedge capture mem_readdata into data[idx]; tag[idx]=latched tag; valid[idx]=1;
//        mem_read=0; cpu_busywait=1; next state IDLE (line re-evaluated, now hits).
//  Miss latency = 1 (IDLE) + memory latency + 1 (UPDATE) cycles, then hit cycle.
//  Replacement: direct-mapped overwrite; no dirty state (read-only cache).
//  Reset mid-operation: any state -> IDLE next posedge; mem_read drops; all valid cleared; in-flight data discarded.
//  Address change during stall: ignored; latched miss address governs fill.
//  Outputs cpu_busywait/cpu_instr combinational from state+hit; mem_read/mem_address registered.
// CONFIGURATION
//  ICACHE_STATS_EN defined: hit_count increments once per IDLE cycle with hit; miss_count once per IDLE->MEM_READ;
//    both reset to 0, wrap at 2**32. Undefined: no counter regs; hit_count/miss_count tied to 32'h0.
// TESTING
//  Bench memory model: 1024-byte array, fixed latency 5 cycles, busywait raised on mem_read rise.
//  Preload words: 0x00=32'h050000FA, 0x04=32'h09010002, 0x08=32'h0A010002, 0x0C=32'h0B010002, 0x80=32'h0D040203.
//  1 Cold miss: reset, cpu_read=1 addr 0x00 -> cpu_busywait=1, mem_read=1 mem_address=28'h0; after fill cpu_instr=32'h050000FA, busywait=0.
//  2 Hits: then addr 0x04,0x08,0x0C consecutive cycles -> busywait=0 each cycle, instr 09010002/0A010002/0B010002, mem_read stays 0.
//  3 Conflict: addr 0x80 (idx 0, new tag) -> miss, mem_address=28'h8, instr 32'h0D040203; then addr 0x00 misses again.
//  4 Reset in MEM_READ (cycle 2 of fill) -> next cycle mem_read=0, busywait=0; addr 0x00 afterwards misses, no mem_read while mem_busywait=1.
//  5 Idle: cpu_read=0 for 10 cycles -> cpu_busywait=0, mem_read=0, cpu_instr unchanged.
//  6 ICACHE_STATS_EN: after scenarios 1-2 hit_count=4 (incl. post-fill hit at 0x00), miss_count=1; undefined -> both 0.

Source files
------------

// File: rtl/ins_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ins_cache_ctrl
// Description : Direct-mapped, read-only instruction cache. Zero-wait hits,
//               stalls the pipeline while a 128-bit block is fetched over the
//               instruction-memory read interface.
//               Optional hit/miss counters: define ICACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ins_cache_ctrl #(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 28 - INDEX_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cpu_read,
    input  logic [31:0]  cpu_address,
    output logic [31:0]  cpu_instr,
    output logic         cpu_busywait,
    output logic         mem_read,
    output logic [27:0]  mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);

    localparam int NUM_BLOCKS = 2 ** INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_READ = 2'd1,
        S_UPDATE   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [127:0]           r_data  [NUM_BLOCKS];
    logic [TAG_W-1:0]       r_tag   [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0]  r_valid;
    logic                   r_mem_read;
    logic [27:0]            r_mem_address;
    logic [31:0]            r_last_instr;

    logic [INDEX_W-1:0]     w_idx;
    logic [TAG_W-1:0]       w_tag;
    logic [1:0]             w_word;
    logic                   w_hit;
    logic                   w_idle_hit;
    logic [31:0]            w_hit_word;
    logic                   w_start_fill;
    logic                   w_fill_done;
    logic [INDEX_W-1:0]     w_fill_idx;
    logic [TAG_W-1:0]       w_fill_tag;
    logic                   w_unused;

    // Address field split; byte offset bits are never used by a word fetch.
    assign w_word   = cpu_address[3:2];
    assign w_idx    = cpu_address[3+INDEX_W:4];
    assign w_tag    = cpu_address[31:4+INDEX_W];
    assign w_unused = &{1'b0, cpu_address[1:0]};

    assign w_hit      = cpu_read & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_idle_hit = (r_state == S_IDLE) & w_hit;
    assign w_hit_word = r_data[w_idx][{w_word, 5'b00000} +: 32];

    // A miss may only start a fill once any stale memory activity has drained.
    assign w_start_fill = (r_state == S_IDLE) & cpu_read & ~w_hit & ~mem_busywait;
    // The block address latched at miss time selects the line being filled.
    assign w_fill_done  = (r_state == S_MEM_READ) & ~mem_busywait;
    assign w_fill_idx   = r_mem_address[INDEX_W-1:0];
    assign w_fill_tag   = r_mem_address[27:INDEX_W];

    assign cpu_busywait = (r_state != S_IDLE) | (cpu_read & ~w_hit);
    assign cpu_instr    = w_idle_hit ? w_hit_word : r_last_instr;
    assign mem_read     = r_mem_read;
    assign mem_address  = r_mem_address;

    // Controller FSM: line valid bits, memory request and last delivered word.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_valid       <= '0;
            r_mem_read    <= 1'b0;
            r_mem_address <= '0;
            r_last_instr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_idle_hit) begin
                        r_last_instr <= w_hit_word;
                    end else if (w_start_fill) begin
                        r_state       <= S_MEM_READ;
                        r_mem_read    <= 1'b1;
                        r_mem_address <= cpu_address[31:4];
                    end
                end
                S_MEM_READ: begin
                    if (!mem_busywait) begin
                        r_state             <= S_UPDATE;
                        r_mem_read          <= 1'b0;
                        r_valid[w_fill_idx] <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_mem_read <= 1'b0;
                end
            endcase
        end
    end

    // Line payload and tag install; no reset needed since valid gates their use.
    always_ff @(posedge clock) begin
        if (w_fill_done) begin
            r_data[w_fill_idx] <= mem_readdata;
            r_tag[w_fill_idx]  <= w_fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Performance counters: one hit per serviced IDLE cycle, one miss per fill start.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_idle_hit)   r_hit_count  <= r_hit_count + 32'd1;
            if (w_start_fill) r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = 32'h0;
    assign miss_count = 32'h0;
`endif

endmodule
`default_nettype wire
